// File: rtl/frame_cfg_pkg.sv
// ============================================================================
// Module  : frame_cfg_pkg
// Brief   : Shared state codes, header field positions and stream constants
//           for the configuration frame writer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package frame_cfg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_HEADER = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_SETUP  = 3'd3;
    localparam state_t ST_STROBE = 3'd4;
    localparam state_t ST_HOLD   = 3'd5;

    localparam int HDR_COL_MSB   = 31;
    localparam int HDR_COL_LSB   = 24;
    localparam int HDR_FRAME_MSB = 23;
    localparam int HDR_FRAME_LSB = 16;

    localparam logic [7:0]  END_OF_CONFIG     = 8'hFF;
    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

endpackage

`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
// ============================================================================
// Module  : frame_strobe_decoder
// Brief   : Column/frame index to one-hot FrameStrobe; all-zero when disabled.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_strobe_decoder #(
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 8
) (
    input  logic [7:0]                            column,
    input  logic [7:0]                            frame,
    input  logic                                  enable,
    output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

    for (genvar c = 0; c < NumColumns; c++) begin : g_col
        for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frame
            localparam logic [7:0] C_COL   = 8'(c);
            localparam logic [7:0] C_FRAME = 8'(f);
            assign strobe[c*MaxFramesPerCol+f] = enable && (column == C_COL) && (frame == C_FRAME);
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_config_writer.sv
// ============================================================================
// Module  : frame_config_writer
// Brief   : Bitstream word stream -> FrameData / one-hot FrameStrobe writer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumColumns      = 8,
    parameter logic [31:0] SyncWord        = DEFAULT_SYNC_WORD
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [31:0]                           WordData,
    input  logic                                  WordValid,
    output logic                                  WordReady,
    output logic [FrameBitsPerRow-1:0]            FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  ConfigBusy,
    output logic                                  ConfigError
);

    if (FrameBitsPerRow > 32 || FrameBitsPerRow < 1) begin : g_widthCheck
        $error("frame_config_writer: FrameBitsPerRow must be 1..32");
    end

    localparam logic [8:0] C_MAX_FRAMES = 9'(MaxFramesPerCol);
    localparam logic [8:0] C_NUM_COLS   = 9'(NumColumns);

    state_t     r_state;
    logic       r_discard;
    logic [7:0] r_col;
    logic [7:0] r_frame;

    logic       w_accept;
    logic [7:0] w_col;
    logic [7:0] w_frame;
    logic       w_isEnd;
    logic       w_badHdr;

    assign w_col    = WordData[HDR_COL_MSB:HDR_COL_LSB];
    assign w_frame  = WordData[HDR_FRAME_MSB:HDR_FRAME_LSB];
    assign w_isEnd  = (w_col == END_OF_CONFIG);
    assign w_badHdr = !w_isEnd && (({1'b0, w_frame} >= C_MAX_FRAMES) || ({1'b0, w_col} >= C_NUM_COLS));

    // Ready is forced low while RST is held so nothing is accepted in the reset cycle.
    assign WordReady = !RST && ((r_state == ST_IDLE) || (r_state == ST_HEADER) || (r_state == ST_DATA));
    assign w_accept  = WordValid && WordReady;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_discard   <= 1'b0;
            r_col       <= '0;
            r_frame     <= '0;
            FrameData   <= '0;
            ConfigBusy  <= 1'b0;
            ConfigError <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (WordData == SyncWord)) begin
                        r_state    <= ST_HEADER;
                        ConfigBusy <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (w_accept) begin
                        if (w_isEnd) begin
                            r_state    <= ST_IDLE;
                            ConfigBusy <= 1'b0;
                        end else if (w_badHdr) begin
                            // Swallow the following data word so the stream stays aligned.
                            ConfigError <= 1'b1;
                            r_discard   <= 1'b1;
                            r_state     <= ST_DATA;
                        end else begin
                            r_col     <= w_col;
                            r_frame   <= w_frame;
                            r_discard <= 1'b0;
                            r_state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= ST_HEADER;
                        end else begin
                            FrameData <= WordData[FrameBitsPerRow-1:0];
                            r_state   <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP:  r_state <= ST_STROBE;
                ST_STROBE: r_state <= ST_HOLD;
                ST_HOLD:   r_state <= ST_HEADER;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumColumns      (NumColumns)
    ) u_strobeDecoder (
        .column (r_col),
        .frame  (r_frame),
        .enable (r_state == ST_STROBE),
        .strobe (FrameStrobe)
    );

endmodule

`default_nettype wire

// File: tb/tb_frame_config_writer.sv
// ============================================================================
// Module  : tb_frame_config_writer
// Brief   : Scoreboard bench for frame_config_writer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_config_writer;

    localparam int          FB   = 32;
    localparam int          MF   = 20;
    localparam int          NC   = 8;
    localparam int          NS   = NC * MF;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [31:0]   WordData = '0;
    logic          WordValid = 1'b0;
    logic          WordReady;
    logic [FB-1:0] FrameData;
    logic [NS-1:0] FrameStrobe;
    logic          ConfigBusy;
    logic          ConfigError;

    frame_config_writer #(
        .FrameBitsPerRow (FB),
        .MaxFramesPerCol (MF),
        .NumColumns      (NC),
        .SyncWord        (SYNC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WordData    (WordData),
        .WordValid   (WordValid),
        .WordReady   (WordReady),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .ConfigBusy  (ConfigBusy),
        .ConfigError (ConfigError)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int nVectors     = 0;
    int nMiscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nMiscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] data;
    } sb_t;
    sb_t sbQ[$];

    // Transaction-level reference: 0 idle, 1 header, 2 data
    int          mState;
    bit          mDisc;
    int          mIdx;
    logic [31:0] mData;
    bit          mErr;
    bit          mBusy;

    task automatic modelReset();
        mState = 0; mDisc = 0; mIdx = 0; mData = '0; mErr = 0; mBusy = 0;
        sbQ.delete();
    endtask

    task automatic modelAccept(input logic [31:0] w);
        int col;
        int fr;
        col = int'(w[31:24]);
        fr  = int'(w[23:16]);
        case (mState)
            0: if (w == SYNC) begin mState = 1; mBusy = 1; end
            1: begin
                if (col == 255) begin
                    mState = 0; mBusy = 0;
                end else if (fr >= MF || col >= NC) begin
                    mErr = 1; mDisc = 1; mState = 2;
                end else begin
                    mIdx = col * MF + fr; mDisc = 0; mState = 2;
                end
            end
            default: begin
                if (mDisc) begin
                    mDisc = 0;
                end else begin
                    mData = w;
                    sbQ.push_back('{mIdx, w});
                end
                mState = 1;
            end
        endcase
    endtask

    // Strobe monitor
    int            strobeCount = 0;
    int            strobeTimes[$];
    bit            countLow = 0;
    int            lowCount = 0;
    logic [NS-1:0] prevStrobe = '0;
    logic [FB-1:0] prevData = '0;
    int            hitIdx;
    sb_t           hitExp;

    always @(negedge CLK) begin
        if (!RST) begin
            if (FrameStrobe != '0) begin
                hitIdx = -1;
                for (int i = 0; i < NS; i++) if (FrameStrobe[i]) hitIdx = i;
                chk("strobeOnehot", 64'($countones(FrameStrobe)), 64'd1);
                chk("strobePulse", 64'(prevStrobe != '0), 64'd0);
                chk("setupStable", 64'(FrameData), 64'(prevData));
                strobeCount++;
                strobeTimes.push_back(cyc);
                if (sbQ.size() == 0) begin
                    chk("unexpectedStrobe", 64'(hitIdx), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    hitExp = sbQ.pop_front();
                    chk("strobeIdx", 64'(hitIdx), 64'(hitExp.idx));
                    chk("strobeData", 64'(FrameData), 64'(hitExp.data));
                end
            end
            if (prevStrobe != '0) chk("holdStable", 64'(FrameData), 64'(prevData));
            if (countLow && !WordReady) lowCount++;
        end
        prevStrobe <= FrameStrobe;
        prevData   <= FrameData;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        int t;
        repeat (gap) begin
            WordValid = 1'b0;
            @(negedge CLK);
        end
        WordData  = w;
        WordValid = 1'b1;
        t = 0;
        while (!WordReady && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!WordReady) begin
            chk("readyTimeout", 64'd0, 64'd1);
            WordValid = 1'b0;
            return;
        end
        @(negedge CLK);
        modelAccept(w);
        chk("busy", 64'(ConfigBusy), 64'(mBusy));
        chk("error", 64'(ConfigError), 64'(mErr));
        chk("frameData", 64'(FrameData), 64'(mData));
    endtask

    task automatic doReset();
        RST = 1'b1;
        WordValid = 1'b0;
        waitCycles(2);
        chk("rstData", 64'(FrameData), 64'd0);
        chk("rstStrobe", 64'(FrameStrobe != '0), 64'd0);
        chk("rstReady", 64'(WordReady), 64'd0);
        chk("rstBusy", 64'(ConfigBusy), 64'd0);
        chk("rstError", 64'(ConfigError), 64'd0);
        RST = 1'b0;
        modelReset();
        waitCycles(1);
        chk("readyAfterRst", 64'(WordReady), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int sc;
    logic [31:0] frameWords[6];

    initial begin
        modelReset();
        @(negedge CLK);

        // Basic single frame into column 2, frame 3
        doReset();
        sc = strobeCount;
        sendWord(SYNC, 0);
        sendWord(32'h0203_0000, 0);
        sendWord(32'hDEAD_BEEF, 0);
        sendWord(32'hFF00_0000, 0);
        WordValid = 1'b0;
        waitCycles(5);
        chk("t1Strobes", 64'(strobeCount - sc), 64'd1);

        // Pre-sync garbage must be discarded
        doReset();
        sc = strobeCount;
        sendWord(32'h1234_5678, 0);
        sendWord(32'h0000_0000, 0);
        WordValid = 1'b0;
        waitCycles(6);
        chk("t2PreSync", 64'(strobeCount - sc), 64'd0);
        sendWord(SYNC, 0);
        sendWord(32'h0713_0000, 0);
        sendWord(32'hA5A5_A5A5, 0);
        sendWord(32'hFF00_0000, 0);
        WordValid = 1'b0;
        waitCycles(5);
        chk("t2Strobes", 64'(strobeCount - sc), 64'd1);

        // Bad header swallows its data word; error is sticky
        sc = strobeCount;
        sendWord(SYNC, 0);
        sendWord(32'h0015_0000, 0);
        sendWord(32'h1111_1111, 0);
        sendWord(32'h0104_0000, 0);
        sendWord(32'h2222_2222, 0);
        sendWord(32'hFF00_0000, 0);
        sendWord(SYNC, 0);
        sendWord(32'hFF00_0000, 0);
        WordValid = 1'b0;
        waitCycles(5);
        chk("t3Strobes", 64'(strobeCount - sc), 64'd1);
        chk("t3StickyErr", 64'(ConfigError), 64'd1);

        // Back-to-back frames in column 0
        doReset();
        sc = strobeCount;
        strobeTimes.delete();
        lowCount = 0;
        countLow = 1;
        sendWord(SYNC, 0);
        for (int f = 0; f < MF; f++) begin
            sendWord({8'h00, 8'(f), 16'h0000}, 0);
            sendWord($urandom, 0);
        end
        sendWord(32'hFF00_0000, 0);
        countLow = 0;
        WordValid = 1'b0;
        waitCycles(5);
        chk("t4Strobes", 64'(strobeCount - sc), 64'(MF));
        for (int i = 1; i < strobeTimes.size(); i++)
            chk("t4Spacing", 64'(strobeTimes[i] - strobeTimes[i-1]), 64'd5);
        chk("t4ReadyLow", 64'(lowCount), 64'(3 * MF));

        // Reset during SETUP cancels the pending strobe
        doReset();
        sendWord(SYNC, 0);
        sendWord(32'h0305_0000, 0);
        sendWord(32'h5555_5555, 0);
        RST = 1'b1;
        WordValid = 1'b0;
        sc = strobeCount;
        waitCycles(1);
        chk("t5RstStrobe", 64'(FrameStrobe != '0), 64'd0);
        chk("t5RstData", 64'(FrameData), 64'd0);
        chk("t5RstBusy", 64'(ConfigBusy), 64'd0);
        RST = 1'b0;
        modelReset();
        waitCycles(5);
        chk("t5NoStrobe", 64'(strobeCount - sc), 64'd0);
        sendWord(32'h0305_0000, 0);
        sendWord(32'h5555_5555, 0);
        WordValid = 1'b0;
        waitCycles(5);
        chk("t5NeedSync", 64'(strobeCount - sc), 64'd0);
        sendWord(SYNC, 0);
        sendWord(32'h0305_0000, 0);
        sendWord(32'h5555_5555, 0);
        sendWord(32'hFF00_0000, 0);
        WordValid = 1'b0;
        waitCycles(5);
        chk("t5AfterSync", 64'(strobeCount - sc), 64'd1);

        // Same frame set without and with random valid gaps
        frameWords[0] = 32'h0000_0000; frameWords[1] = 32'h0513_0000;
        frameWords[2] = 32'h0709_0000; frameWords[3] = 32'h0101_0000;
        frameWords[4] = 32'h0410_0000; frameWords[5] = 32'h0602_0000;
        for (int pass = 0; pass < 2; pass++) begin
            doReset();
            sc = strobeCount;
            sendWord(SYNC, (pass == 0) ? 0 : int'($urandom_range(0, 4)));
            for (int k = 0; k < 6; k++) begin
                sendWord(frameWords[k], (pass == 0) ? 0 : int'($urandom_range(0, 4)));
                sendWord(32'hC0DE_0000 + 32'(k), (pass == 0) ? 0 : int'($urandom_range(0, 4)));
            end
            sendWord(32'hFF00_0000, (pass == 0) ? 0 : int'($urandom_range(0, 4)));
            WordValid = 1'b0;
            waitCycles(5);
            chk("t6Strobes", 64'(strobeCount - sc), 64'd6);
        end

        waitCycles(10);
        chk("sbDrain", 64'(sbQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

`default_nettype wire
